// File: rtl/mem_bist_ctrl_pkg.sv
// Shared definitions for the memory BIST controller: default geometry,
// controller state encoding and the pattern increment constant.
package mem_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 256;
    localparam int ADDR_DEF  = 8;

    // Golden-ratio increment; callers truncate it to their data width.
    localparam logic [31:0] PAT_INC = 32'h9E3779B9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        TURN  = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_bist_ctrl_if.sv
// Memory request/response bus between the BIST controller (master) and the
// memory under test (slave).
interface mem_bist_ctrl_if
    import mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ADDR  = ADDR_DEF
) ();

    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] wdata;
    logic             wrbar;
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] rdata;

    modport master (
        output addr, wdata, wrbar, valid,
        input  ready, rdata
    );

    modport slave (
        input  addr, wdata, wrbar, valid,
        output ready, rdata
    );

endinterface

// File: rtl/mem_bist_ctrl_pattern.sv
// Data pattern generator: an accumulator that loads a seed and then adds a
// fixed increment on every step, giving P(k) = seed + k*INC without a multiplier.
module mem_bist_pattern #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INC   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] pat_o
);

    logic [WIDTH-1:0] pat_q;

    // Accumulator: load wins over step so a phase always restarts from the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
        end else if (load_i) begin
            pat_q <= seed_i;
        end else if (step_i) begin
            pat_q <= pat_q + INC;
        end else begin
            pat_q <= pat_q;
        end
    end

    assign pat_o = pat_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes a seeded arithmetic pattern over an address
// window, turns the bus around for one cycle, reads the window back and
// reports mismatch count, first failing address and a pass flag.
module mem_bist_ctrl
    import mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ADDR  = ADDR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDR-1:0]  start_addr,
    input  logic [ADDR:0]    num_loc,
    input  logic [WIDTH-1:0] seed,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ADDR:0]    err_count,
    output logic [ADDR-1:0]  first_err_addr,
    mem_bist_ctrl_if.master  mem
);

    localparam logic [ADDR:0]   DEPTH_W  = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0]   ONE_CNT  = (ADDR+1)'(1);
    localparam logic [ADDR-1:0] ONE_ADDR = ADDR'(1);

    state_t           state_q, state_d;
    logic [ADDR-1:0]  start_addr_q;
    logic [ADDR:0]    num_q;
    logic [WIDTH-1:0] seed_q;
    logic [ADDR-1:0]  addr_q;
    logic [ADDR:0]    cnt_q;
    logic             busy_q, done_q, pass_q;
    logic [ADDR:0]    err_q;
    logic [ADDR-1:0]  first_q;

    logic             valid_s, wrbar_s;
    logic [ADDR-1:0]  addr_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] pat_s;
    logic [WIDTH-1:0] load_val_s;
    logic             load_s;
    logic [ADDR:0]    num_clamp_s;
    logic             accept_s, beat_s, last_s, mismatch_s;

    assign num_clamp_s = (num_loc > DEPTH_W) ? DEPTH_W : num_loc;
    assign accept_s    = (state_q == IDLE) && start;
    assign beat_s      = valid_s && mem.ready;
    assign last_s      = (cnt_q == (num_q - ONE_CNT));
    assign mismatch_s  = (state_q == READ) && beat_s && (mem.rdata != pat_s);

    // Pattern reload source: live seed on acceptance, captured seed before READ.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = seed_q;
        if (accept_s) begin
            load_s     = 1'b1;
            load_val_s = seed;
        end else if (state_q == TURN) begin
            load_s     = 1'b1;
            load_val_s = seed_q;
        end else begin
            load_s     = 1'b0;
            load_val_s = seed_q;
        end
    end

    mem_bist_pattern #(
        .WIDTH (WIDTH),
        .INC   (WIDTH'(PAT_INC))
    ) u_pattern (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_s),
        .seed_i (load_val_s),
        .step_i (beat_s),
        .pat_o  (pat_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; beats only advance the phase when they complete.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_clamp_s == '0) ? DONE : WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (beat_s && last_s) begin
                    state_d = TURN;
                end else begin
                    state_d = WRITE;
                end
            end
            TURN: state_d = READ;
            READ: begin
                if (beat_s && last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs: driven only in the two transfer phases, zero elsewhere.
    always_comb begin
        valid_s = 1'b0;
        wrbar_s = 1'b0;
        addr_s  = '0;
        wdata_s = '0;
        case (state_q)
            WRITE: begin
                valid_s = 1'b1;
                wrbar_s = 1'b1;
                addr_s  = addr_q;
                wdata_s = pat_s;
            end
            READ: begin
                valid_s = 1'b1;
                wrbar_s = 1'b0;
                addr_s  = addr_q;
                wdata_s = '0;
            end
            default: begin
                valid_s = 1'b0;
                wrbar_s = 1'b0;
                addr_s  = '0;
                wdata_s = '0;
            end
        endcase
    end

    // Datapath: command capture, beat address/count, and result bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_addr_q <= '0;
            num_q        <= '0;
            seed_q       <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_q      <= '0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        start_addr_q <= start_addr;
                        num_q        <= num_clamp_s;
                        seed_q       <= seed;
                        addr_q       <= start_addr;
                        cnt_q        <= '0;
                        pass_q       <= 1'b0;
                        err_q        <= '0;
                        first_q      <= '0;
                    end else begin
                        addr_q <= addr_q;
                    end
                end
                WRITE: begin
                    if (beat_s) begin
                        addr_q <= addr_q + ONE_ADDR;
                        cnt_q  <= cnt_q + ONE_CNT;
                    end else begin
                        addr_q <= addr_q;
                    end
                end
                TURN: begin
                    addr_q <= start_addr_q;
                    cnt_q  <= '0;
                end
                READ: begin
                    if (beat_s) begin
                        addr_q <= addr_q + ONE_ADDR;
                        cnt_q  <= cnt_q + ONE_CNT;
                    end else begin
                        addr_q <= addr_q;
                    end
                    if (mismatch_s) begin
                        err_q <= err_q + ONE_CNT;
                        if (err_q == '0) begin
                            first_q <= addr_q;
                        end else begin
                            first_q <= first_q;
                        end
                    end else begin
                        err_q <= err_q;
                    end
                end
                DONE: begin
                    pass_q <= (err_q == '0);
                end
                default: begin
                    addr_q <= addr_q;
                end
            endcase
        end
    end

    assign mem.valid      = valid_s;
    assign mem.wrbar      = wrbar_s;
    assign mem.addr       = addr_s;
    assign mem.wdata      = wdata_s;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench for mem_bist_ctrl: a behavioural memory plus an
// expected beat list derived directly from the address/pattern rules.
module tb_mem_bist_ctrl;

    localparam logic [31:0] PAT_INC_REF = 32'h9E3779B9;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  start_addr;
    logic [8:0]  num_loc;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [8:0]  err_count;
    logic [7:0]  first_err_addr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_model [256];
    int          wcount    [256];

    typedef struct {
        bit          turn;
        bit          wr;
        logic [7:0]  a;
        logic [31:0] d;
    } beat_t;

    mem_bist_ctrl_if #(.WIDTH(32), .ADDR(8)) mem_if ();

    mem_bist_ctrl #(.WIDTH(32), .DEPTH(256), .ADDR(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_addr     (start_addr),
        .num_loc        (num_loc),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .mem            (mem_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(mem_if.valid), 64'd0);
        chk({tag, "_wrbar"}, 64'(mem_if.wrbar), 64'd0);
        chk({tag, "_addr"},  64'(mem_if.addr), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_if.wdata), 64'd0);
        chk({tag, "_done"},  64'(done), 64'd0);
        chk({tag, "_pass"},  64'(pass), 64'd0);
        chk({tag, "_err"},   64'(err_count), 64'd0);
        chk({tag, "_first"}, 64'(first_err_addr), 64'd0);
    endtask

    // One complete BIST run. abort_at >= 0 asserts rst while write beat
    // abort_at is on the bus and ends the run there.
    task automatic run_test(input logic [7:0] sa, input logic [8:0] nl, input logic [31:0] sd,
                            input int stall_max, input bit inj, input int abort_at);
        beat_t       q[$];
        beat_t       e;
        int          n, i, cycles, stall_left, exp_err, nwrites;
        logic [7:0]  exp_first;
        logic [7:0]  a;
        n         = (nl > 9'd256) ? 256 : int'(nl);
        exp_err   = 0;
        exp_first = 8'd0;
        nwrites   = 0;
        for (int k = 0; k < 256; k++) wcount[k] = 0;
        for (int k = 0; k < n; k++) begin
            a = 8'(32'(sa) + k);
            q.push_back('{turn: 1'b0, wr: 1'b1, a: a, d: sd + 32'(k) * PAT_INC_REF});
        end
        if (n > 0) q.push_back('{turn: 1'b1, wr: 1'b0, a: 8'd0, d: 32'd0});
        for (int k = 0; k < n; k++) begin
            a = 8'(32'(sa) + k);
            q.push_back('{turn: 1'b0, wr: 1'b0, a: a, d: 32'd0});
            if (inj && (a == 8'd5 || a == 8'd9)) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end

        @(negedge clk);
        start      = 1'b1;
        start_addr = sa;
        num_loc    = nl;
        seed       = sd;
        mem_if.ready = 1'b0;
        @(negedge clk);
        start      = 1'b0;
        start_addr = 8'($urandom);
        num_loc    = 9'($urandom);
        seed       = $urandom;
        chk("start_busy",  64'(busy), 64'd1);
        chk("start_pass_clr", 64'(pass), 64'd0);
        chk("start_err_clr",  64'(err_count), 64'd0);
        chk("start_first_clr", 64'(first_err_addr), 64'd0);

        i          = 0;
        cycles     = 0;
        stall_left = $urandom_range(0, stall_max);
        while (i < q.size() && cycles < 4000) begin
            e = q[i];
            if (!e.turn && e.wr && abort_at >= 0 && i == abort_at) begin
                rst = 1'b1;
                #1;
                chk_reset_vals("abort");
                @(negedge clk);
                rst          = 1'b0;
                mem_if.ready = 1'b0;
                return;
            end
            if (e.turn) begin
                chk("turn_valid", 64'(mem_if.valid), 64'd0);
                chk("turn_busy",  64'(busy), 64'd1);
                mem_if.ready = 1'($urandom);
                mem_if.rdata = $urandom;
                i++;
            end else begin
                chk(e.wr ? "wr_valid" : "rd_valid", 64'(mem_if.valid), 64'd1);
                chk(e.wr ? "wr_wrbar" : "rd_wrbar", 64'(mem_if.wrbar), 64'(e.wr));
                chk(e.wr ? "wr_addr"  : "rd_addr",  64'(mem_if.addr), 64'(e.a));
                chk(e.wr ? "wr_wdata" : "rd_wdata", 64'(mem_if.wdata), 64'(e.d));
                if (stall_left > 0) begin
                    stall_left--;
                    mem_if.ready = 1'b0;
                    mem_if.rdata = $urandom;
                end else begin
                    mem_if.ready = 1'b1;
                    if (mem_if.wrbar) begin
                        mem_model[mem_if.addr] = mem_if.wdata;
                        wcount[mem_if.addr]++;
                        nwrites++;
                        mem_if.rdata = $urandom;
                    end else begin
                        mem_if.rdata = mem_model[mem_if.addr] ^
                            ((inj && (mem_if.addr == 8'd5 || mem_if.addr == 8'd9)) ? 32'd1 : 32'd0);
                    end
                    stall_left = $urandom_range(0, stall_max);
                    i++;
                end
            end
            start      = ($urandom_range(0, 5) == 0);
            start_addr = 8'($urandom);
            @(negedge clk);
            cycles++;
        end
        chk("beats_done_in_budget", 64'(i), 64'(q.size()));

        start        = 1'b0;
        mem_if.ready = 1'b0;
        chk("done_state_valid", 64'(mem_if.valid), 64'd0);
        chk("done_state_pulse", 64'(done), 64'd0);
        @(negedge clk);
        chk("done_pulse",  64'(done), 64'd1);
        chk("done_pass",   64'(pass), 64'(exp_err == 0));
        chk("done_err",    64'(err_count), 64'(exp_err));
        chk("done_first",  64'(first_err_addr), 64'(exp_first));
        chk("done_busy",   64'(busy), 64'd0);
        chk("done_valid",  64'(mem_if.valid), 64'd0);
        chk("write_total", 64'(nwrites), 64'(n));
        for (int k = 0; k < n; k++) begin
            chk("write_once", 64'(wcount[8'(32'(sa) + k)]), 64'd1);
        end
        @(negedge clk);
        chk("after_done_low", 64'(done), 64'd0);
        chk("hold_pass", 64'(pass), 64'(exp_err == 0));
        chk("hold_err",  64'(err_count), 64'(exp_err));
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        start_addr   = 8'd0;
        num_loc      = 9'd0;
        seed         = 32'd0;
        mem_if.ready = 1'b0;
        mem_if.rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Basic sweep from address 0 with a zero seed.
        run_test(8'h00, 9'd32, 32'd0, 0, 1'b0, -1);
        // Window wrapping past the top of the address space.
        run_test(8'hF0, 9'd32, $urandom, 0, 1'b0, -1);
        // Faulty memory at addresses 5 and 9.
        run_test(8'h00, 9'd16, $urandom, 0, 1'b1, -1);
        // Random ready stalls.
        for (int r = 0; r < 4; r++) begin
            run_test(8'($urandom), 9'($urandom_range(1, 64)), $urandom, 3, 1'b0, -1);
        end
        // Empty and over-sized windows.
        run_test(8'($urandom), 9'd0, $urandom, 0, 1'b0, -1);
        run_test(8'($urandom), 9'd300, $urandom, 0, 1'b0, -1);
        // Reset in the middle of write beat 10, then a clean run.
        run_test(8'($urandom), 9'd40, $urandom, 1, 1'b0, 10);
        run_test(8'($urandom), 9'd20, $urandom, 2, 1'b0, -1);
        // Random window over the faulty memory.
        run_test(8'($urandom), 9'($urandom_range(1, 300)), $urandom, 1, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: memory data width in bits.
REQ-002 Parameter DEPTH, default 256: number of memory locations.
REQ-003 Parameter ADDR, default 8: memory address width; DEPTH SHALL be 2**ADDR.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  command strobe; sampled only in IDLE.
REQ-007 start_addr  input  ADDR  first location of the test window.
REQ-008 num_loc  input  ADDR+1  locations to test; values above DEPTH clamp to DEPTH.
REQ-009 seed  input  WIDTH  initial data pattern.
REQ-010 busy  output  1  high from the cycle after start is accepted until DONE is exited.
REQ-011 addr  output  ADDR  memory address.
REQ-012 wdata  output  WIDTH  memory write data.
REQ-013 wrbar  output  1  1 = write, 0 = read.
REQ-014 valid  output  1  request to the memory.
REQ-015 ready  input  1  memory acceptance / read-data-valid.
REQ-016 rdata  input  WIDTH  memory read data, valid in a cycle with valid && ready && !wrbar.
REQ-017 done  output  1  one-cycle pulse at test completion.
REQ-018 pass  output  1  1 when the last test had zero mismatches.
REQ-019 err_count  output  ADDR+1  mismatch count of the last test.
REQ-020 first_err_addr  output  ADDR  address of the first mismatch; 0 if none.

Function
REQ-021 States SHALL be IDLE, WRITE, TURN, READ, DONE.
REQ-022 IDLE plus start: capture start_addr, clamped num_loc and seed; go to WRITE, or to DONE if num_loc = 0.
REQ-023 A beat SHALL complete on a rising edge where valid && ready are both high.
REQ-024 valid SHALL rise in the first cycle after start is captured (latency 1).
REQ-025 valid SHALL stay high and addr/wdata/wrbar stable until the beat completes.
REQ-026 Beats SHALL be back-to-back with no idle cycle within a phase.
REQ-027 Beat k SHALL use addr = (start_addr + k) mod 2**ADDR; wrap-around is legal.
REQ-028 Beat k data pattern SHALL be P(k) = seed + k*PAT_INC, truncated to WIDTH.
REQ-029 The pattern SHALL be produced by an accumulator, not a multiplier.
REQ-030 WRITE SHALL issue num_loc beats with wrbar=1 and wdata=P(k), then go to TURN.
REQ-031 TURN SHALL last exactly 1 cycle with valid=0, then go to READ.
REQ-032 READ SHALL issue num_loc beats with wrbar=0 and wdata=0.
REQ-033 On each completing READ beat, rdata SHALL be compared with P(k).
REQ-034 On a mismatch, err_count SHALL increment; on the first mismatch, that beat's addr SHALL be latched into first_err_addr.
REQ-035 After the last READ beat, go to DONE.
REQ-036 DONE SHALL assert done for 1 cycle with pass = (err_count == 0), then return to IDLE.
REQ-037 pass, err_count and first_err_addr SHALL hold until the next accepted start, which clears them.
REQ-038 start while busy SHALL be ignored.
REQ-039 Outside WRITE and READ: valid=0, wrbar=0, addr=0, wdata=0.
REQ-040 If ready never rises, the block SHALL wait indefinitely; there is no timeout.

Reset
REQ-041 rst SHALL force IDLE immediately, including mid-beat; valid drops without waiting for ready.
REQ-042 Reset values: busy=0, valid=0, wrbar=0, addr=0, wdata=0, done=0, pass=0, err_count=0, first_err_addr=0.

Structure
REQ-043 A shared package mem_pkg SHALL hold: default WIDTH/DEPTH/ADDR, the state enumeration, and PAT_INC = 32'h9E3779B9 truncated to WIDTH.
REQ-044 Sub-module mem_bist_pattern (accumulator with load-seed and step ports) SHALL generate P(k) and be instantiated once.
REQ-045 The pattern SHALL be reloaded from seed on entry to READ.

Verification
REQ-046 seed=0, start_addr=0, num_loc=32, memory ready=1 always -> 32 writes (addr 0..31, data k*PAT_INC), 1 TURN cycle, 32 reads, done pulse, pass=1, err_count=0.
REQ-047 start_addr=8'hF0, num_loc=32 -> addresses F0..FF then 00..0F in both phases; pass=1.
REQ-048 Memory model flips bit 0 of rdata at addresses 5 and 9, num_loc=16 -> err_count=2, first_err_addr=5, pass=0.
REQ-049 Random ready stalls of 0-3 cycles -> addr/wdata stable while stalled, each location written exactly once, pass=1.
REQ-050 num_loc=0 -> done on the 2nd cycle after start with no valid; num_loc=300 -> exactly 256 beats per phase.
REQ-051 rst asserted during WRITE beat 10 -> valid=0 the same cycle, all outputs at reset values; a following start runs to pass=1.
